wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be: N_REGS, default 32, number of architectural registers; R_WIDTH, default 32, register width; N_SRC, default 3, number of writeback sources (0=ALU, 1=LSU, 2=MUL/DIV); W_ADDR is derived as clog2(N_REGS).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 src_valid  in  N_SRC  per-source result valid.
REQ-005 src_ready  out  N_SRC  per-source accept; a result transfers when valid and ready are both high.
REQ-006 src_addr  in  N_SRC x W_ADDR  destination register per source.
REQ-007 src_data  in  N_SRC x R_WIDTH  result data per source.
REQ-008 rf_write  out  1  register-file write enable, driving the register file's single write port.
REQ-009 rf_addr  out  W_ADDR  register-file write address.
REQ-010 rf_data  out  R_WIDTH  register-file write data.
REQ-011 reserve_valid  in  1  issue stage claims a destination register.
REQ-012 reserve_addr  in  W_ADDR  register being claimed.
REQ-013 busy  out  N_REGS  per-register pending-write flags.

Function
REQ-014 The block SHALL accept at most one source per cycle and SHALL select it by round-robin among asserted src_valid bits.
REQ-015 Search order SHALL start at (last_grant+1) mod N_SRC; last_grant SHALL update only on an accepted transfer.
REQ-016 src_ready SHALL be combinational and one-hot or zero: src_ready[i]=1 only for the granted source; it SHALL NOT depend on src_ready.
REQ-017 An accepted transfer in cycle N SHALL produce rf_write=1 with that addr/data in cycle N+1 from a registered output stage; latency is exactly 1 cycle.
REQ-018 The output stage SHALL never stall; the register file always accepts, so full throughput is 1 write per cycle.
REQ-019 A transfer with src_addr=0 SHALL be accepted (ready asserted) but SHALL NOT assert rf_write.
REQ-020 With no accepted transfer in cycle N, rf_write SHALL be 0 in cycle N+1; rf_addr/rf_data SHALL hold their previous values.
REQ-021 A source whose valid drops without acceptance SHALL lose no state; its valid may not be withdrawn once asserted until accepted.

Reset
REQ-022 While rst=1: rf_write=0, rf_addr=0, rf_data=0, busy=all 0, last_grant=N_SRC-1, so source 0 has highest priority in the first arbitration after reset.
REQ-023 src_ready SHALL be all 0 during any cycle with rst=1.
REQ-024 A transfer in flight when rst asserts SHALL be discarded; no rf_write SHALL follow reset.

Configuration
REQ-025 Macro WB_SCOREBOARD_EN SHALL gate the scoreboard.
REQ-026 With WB_SCOREBOARD_EN defined: reserve_valid with reserve_addr!=0 SHALL set busy[reserve_addr] in the next cycle; rf_write=1 SHALL clear busy[rf_addr] in the next cycle; on a simultaneous set and clear of the same register, set SHALL win; reserving an already-busy register SHALL leave it set; busy[0] SHALL be constant 0.
REQ-027 Without WB_SCOREBOARD_EN: busy SHALL be tied to 0, reserve inputs SHALL be ignored, and no scoreboard flops SHALL be synthesized.

Structure
REQ-028 Shared package core_pkg SHALL hold W_ADDR, the source-index enum (SRC_ALU, SRC_LSU, SRC_MUL) and the struct wb_req_t {addr, data}.
REQ-029 Round-robin selection SHALL live in sub-module rr_arbiter (parameter N, inputs req and advance, output one-hot gnt, internal pointer).
REQ-030 The register-file bypass of rf_data on a same-address read SHALL remain in the register file; this block adds no bypass.

Verification
REQ-031 Single source: ALU valid, addr=5, data=0xDEADBEEF in cycle 3 -> ready[0]=1 in cycle 3; rf_write=1, rf_addr=5, rf_data=0xDEADBEEF in cycle 4.
REQ-032 Contention: all three valid for 6 cycles after reset -> grant order 0,1,2,0,1,2; rf_write high for 6 consecutive cycles.
REQ-033 x0 drop: LSU valid, addr=0, data=0x1234 -> ready[1]=1; rf_write stays 0.
REQ-034 Scoreboard (macro on): reserve x7 in cycle 1 -> busy[7]=1 from cycle 2; ALU writes x7 in cycle 4 -> rf_write in cycle 5, busy[7]=0 in cycle 6; a reserve of x7 in cycle 5 keeps busy[7]=1.
REQ-035 Reset mid-operation: transfer accepted in cycle N with rst=1 in cycle N+1 -> rf_write=0 and busy=0; the next post-reset grant goes to source 0.
REQ-036 Macro off: reserve x9 -> busy stays 0 in all cycles.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared writeback types and default sizes
// Holds the default register-file geometry, the writeback source index
// enum and the writeback request struct used by the arbiter and its users.
package core_pkg;

  localparam int N_REGS_DEF  = 32;
  localparam int R_WIDTH_DEF = 32;
  localparam int N_SRC_DEF   = 3;
  localparam int W_ADDR      = $clog2(N_REGS_DEF);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MUL = 2'd2
  } src_e;

  typedef struct packed {
    logic [W_ADDR-1:0]      addr;
    logic [R_WIDTH_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback bus between result sources and the arbiter
// Signals: src_valid/src_ready/src_addr/src_data (per-source result handshake),
//   rf_write/rf_addr/rf_data (register-file write port),
//   reserve_valid/reserve_addr (issue-stage claims), busy (pending-write flags).
// Modports: master = sources/issue side, slave = wb_arbiter.
interface wb_arbiter_if
  import core_pkg::*;
#(
  parameter int N_REGS  = N_REGS_DEF,
  parameter int R_WIDTH = R_WIDTH_DEF,
  parameter int N_SRC   = N_SRC_DEF
);
  localparam int AW = $clog2(N_REGS);

  logic [N_SRC-1:0]              src_valid;
  logic [N_SRC-1:0]              src_ready;
  logic [N_SRC-1:0][AW-1:0]      src_addr;
  logic [N_SRC-1:0][R_WIDTH-1:0] src_data;
  logic                          rf_write;
  logic [AW-1:0]                 rf_addr;
  logic [R_WIDTH-1:0]            rf_data;
  logic                          reserve_valid;
  logic [AW-1:0]                 reserve_addr;
  logic [N_REGS-1:0]             busy;

  modport master (
    output src_valid, src_addr, src_data, reserve_valid, reserve_addr,
    input  src_ready, rf_write, rf_addr, rf_data, busy
  );

  modport slave (
    input  src_valid, src_addr, src_data, reserve_valid, reserve_addr,
    output src_ready, rf_write, rf_addr, rf_data, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with registered last-grant pointer
// Ports: clk, rst (sync, active-high); i_req (N request bits);
//   i_advance (grant was taken, move pointer); o_gnt (one-hot or zero grant).
module rr_arbiter
  import core_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_last;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_idx;
  logic          w_found;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % N);
  endfunction

  // Scan starts one past the last winner so every requester is served
  // within N accepted transfers.
  always_comb begin
    o_gnt   = '0;
    w_sel   = r_last;
    w_idx   = '0;
    w_found = 1'b0;
    if (!rst) begin
      for (int k = 1; k <= N; k++) begin
        w_idx = wrap(int'(r_last) + k);
        if (!w_found && i_req[w_idx]) begin
          w_found = 1'b1;
          w_sel   = w_idx;
        end
      end
      if (w_found) o_gnt[w_sel] = 1'b1;
    end
  end

  // Reset to N-1 so source 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= PW'(N - 1);
    end else if (i_advance && w_found) begin
      r_last <= w_sel;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter with optional busy scoreboard
// Ports: clk, rst (sync, active-high); wb (wb_arbiter_if.slave): per-source
//   result handshake in, single register-file write port out (1-cycle latency),
//   reserve claims in, busy flags out.
// Config: define WB_SCOREBOARD_EN to build the per-register busy scoreboard;
//   otherwise busy is tied to zero and reserve inputs are ignored.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int N_REGS  = N_REGS_DEF,
  parameter int R_WIDTH = R_WIDTH_DEF,
  parameter int N_SRC   = N_SRC_DEF
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave wb
);
  localparam int AW = $clog2(N_REGS);

  logic [N_SRC-1:0]   w_gnt;
  logic               w_accept;
  logic [AW-1:0]      w_addr;
  logic [R_WIDTH-1:0] w_data;

  logic               r_write;
  logic [AW-1:0]      r_addr;
  logic [R_WIDTH-1:0] r_data;

  rr_arbiter #(.N(N_SRC)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (wb.src_valid),
    .i_advance (w_accept),
    .o_gnt     (w_gnt)
  );

  // Grant only ever lands on a valid source, so any grant is a transfer.
  assign wb.src_ready = w_gnt;
  assign w_accept     = |w_gnt;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_gnt[i]) begin
        w_addr = wb.src_addr[i];
        w_data = wb.src_data[i];
      end
    end
  end

  // Writes to x0 are swallowed: accepted, but the port and its held
  // address/data are left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_write <= w_accept && (w_addr != '0);
      if (w_accept && (w_addr != '0)) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  // Outputs are masked by rst so a write registered just before reset
  // never reaches the register file.
  assign wb.rf_write = r_write & ~rst;
  assign wb.rf_addr  = rst ? '0 : r_addr;
  assign wb.rf_data  = rst ? '0 : r_data;

`ifdef WB_SCOREBOARD_EN
  logic [N_REGS-1:0] r_busy;
  logic [N_REGS-1:0] w_busy_nxt;

  // Set is applied after clear so a same-register reserve wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_write) w_busy_nxt[r_addr] = 1'b0;
    if (wb.reserve_valid) w_busy_nxt[wb.reserve_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign wb.busy = rst ? '0 : r_busy;
`else
  logic w_unused;
  assign w_unused = ^{wb.reserve_valid, wb.reserve_addr};
  assign wb.busy  = '0;
`endif

endmodule
